// File: rtl/pulse_gen_if.sv
// -----------------------------------------------------------------------------
// pulse_gen_if : host-side bundle for the test-pulse generator.
//
// Signals:
//   fire_pulse   host -> gen   level; rising edge requests a pulse
//   bx_delay     host -> gen   start delay in clk cycles (0..7)
//   pulse_width  host -> gen   pulse length code, length = code+1 (1..16)
//   cnt_rst      host -> gen   synchronous clear of pulse_cnt
//   pulse_out    gen  -> host  registered pulse to the analog pulser
//   check_strobe gen  -> host  one-cycle strobe on the last pulse cycle
//   pulser_ready gen  -> host  high only while the generator is idle
//   pulse_cnt    gen  -> host  fired-pulse count, wraps
//   busy_drop    gen  -> host  one-cycle flag for an ignored fire edge
//
// Modports: master (host / testbench side), slave (pulse_gen side).
// -----------------------------------------------------------------------------
interface pulse_gen_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             fire_pulse;
  logic [2:0]       bx_delay;
  logic [3:0]       pulse_width;
  logic             cnt_rst;
  logic             pulse_out;
  logic             check_strobe;
  logic             pulser_ready;
  logic [CNT_W-1:0] pulse_cnt;
  logic             busy_drop;

  modport master (
    output fire_pulse, bx_delay, pulse_width, cnt_rst,
    input  pulse_out, check_strobe, pulser_ready, pulse_cnt, busy_drop
  );

  modport slave (
    input  fire_pulse, bx_delay, pulse_width, cnt_rst,
    output pulse_out, check_strobe, pulser_ready, pulse_cnt, busy_drop
  );
endinterface

// File: rtl/pulse_gen.sv
// -----------------------------------------------------------------------------
// pulse_gen : turns the host fire_pulse level bit into one timed test pulse.
//
// A rising edge of fire_pulse in IDLE latches bx_delay / pulse_width, waits
// bx_delay cycles, drives pulse_out for pulse_width+1 cycles (check_strobe on
// the last one), then holds off for HOLDOFF cycles before re-arming.
//
// Ports:
//   i_clk    system clock
//   i_reset  synchronous, active-high reset
//   bus      pulse_gen_if.slave (fire/delay/width/cnt_rst in; pulse_out,
//            check_strobe, pulser_ready, pulse_cnt, busy_drop out)
//
// Parameters:
//   HOLDOFF  idle cycles after a pulse before a new fire is accepted (1..255)
//   CNT_W    width of the fired-pulse counter (must match the interface)
//
// Optional build macro: PULSE_GEN_REARM_EN
//   When defined, one fire edge seen while busy is remembered and fired
//   straight out of HOLDOFF; busy_drop then flags only a second busy edge.
// -----------------------------------------------------------------------------
module pulse_gen #(
  parameter int unsigned HOLDOFF = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic             r_fire_q;
  logic [2:0]       r_dly_cnt, w_dly_nxt;
  logic [3:0]       r_wid_cnt, w_wid_nxt;
  logic [7:0]       r_hold_cnt, w_hold_nxt;
  logic             r_pulse_out, r_check_strobe, r_ready, r_busy_drop;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic             w_fire_edge, w_accept, w_busy_drop;
`ifdef PULSE_GEN_REARM_EN
  logic             r_pending, w_pending_nxt;
`endif

  assign w_fire_edge = bus.fire_pulse & ~r_fire_q;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly_cnt;
    w_wid_nxt   = r_wid_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_accept    = 1'b0;
    w_busy_drop = 1'b0;
`ifdef PULSE_GEN_REARM_EN
    w_pending_nxt = r_pending;
`endif

    // Fire edges outside IDLE never start a pulse directly.
    if (w_fire_edge && (r_state != S_IDLE)) begin
`ifdef PULSE_GEN_REARM_EN
      if (r_pending) w_busy_drop   = 1'b1;
      else           w_pending_nxt = 1'b1;
`else
      w_busy_drop = 1'b1;
`endif
    end

    case (r_state)
      S_IDLE: w_accept = w_fire_edge;
      S_DELAY: begin
        // Entered with dly_cnt = bx_delay, so this spends bx_delay cycles here.
        w_dly_nxt = r_dly_cnt - 3'd1;
        if (r_dly_cnt == 3'd1) w_state_nxt = S_PULSE;
      end
      S_PULSE: begin
        if (r_wid_cnt == 4'd0) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = 8'(HOLDOFF - 1);
        end else begin
          w_wid_nxt = r_wid_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
`ifdef PULSE_GEN_REARM_EN
          // A remembered edge (or one arriving right now) fires immediately.
          if (w_pending_nxt) begin
            w_accept      = 1'b1;
            w_pending_nxt = 1'b0;
          end
`endif
        end else begin
          w_hold_nxt = r_hold_cnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_accept) begin
      w_dly_nxt   = bus.bx_delay;
      w_wid_nxt   = bus.pulse_width;
      w_state_nxt = (bus.bx_delay != 3'd0) ? S_DELAY : S_PULSE;
    end
  end

  // Outputs are registered from the next-state view so they line up with the
  // state they describe, one cycle after the decision.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      // Reset high: a fire_pulse level held through reset is not an edge.
      r_fire_q       <= 1'b1;
      r_dly_cnt      <= 3'd0;
      r_wid_cnt      <= 4'd0;
      r_hold_cnt     <= 8'd0;
      r_pulse_out    <= 1'b0;
      r_check_strobe <= 1'b0;
      r_ready        <= 1'b1;
      r_busy_drop    <= 1'b0;
      r_pulse_cnt    <= '0;
`ifdef PULSE_GEN_REARM_EN
      r_pending      <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_fire_q       <= bus.fire_pulse;
      r_dly_cnt      <= w_dly_nxt;
      r_wid_cnt      <= w_wid_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_pulse_out    <= (w_state_nxt == S_PULSE);
      r_check_strobe <= (w_state_nxt == S_PULSE) && (w_wid_nxt == 4'd0);
      r_ready        <= (w_state_nxt == S_IDLE);
      r_busy_drop    <= w_busy_drop;
`ifdef PULSE_GEN_REARM_EN
      r_pending      <= w_pending_nxt;
`endif
      // Count on entry to PULSE; a clear in the same cycle takes priority.
      if (bus.cnt_rst)
        r_pulse_cnt <= '0;
      else if ((w_state_nxt == S_PULSE) && (r_state != S_PULSE))
        r_pulse_cnt <= r_pulse_cnt + CNT_ONE;
    end
  end

  assign bus.pulse_out    = r_pulse_out;
  assign bus.check_strobe = r_check_strobe;
  assign bus.pulser_ready = r_ready;
  assign bus.pulse_cnt    = r_pulse_cnt;
  assign bus.busy_drop    = r_busy_drop;

endmodule

// File: tb/tb_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_gen : directed self-checking bench for pulse_gen (CNT_W = 4,
// HOLDOFF = 8). Cycle k counts posedges after the cycle in which fire_pulse
// is raised; outputs are sampled 1 ns after each posedge.
// -----------------------------------------------------------------------------
module tb_pulse_gen;
  localparam int unsigned HOLDOFF = 8;
  localparam int unsigned CNT_W   = 4;
`ifdef PULSE_GEN_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  pulse_gen_if #(.CNT_W(CNT_W)) bus ();

  pulse_gen #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Fire one pulse and check every cycle up to the first IDLE cycle.
  // Inputs are scrambled after acceptance to show they are not resampled.
  task automatic fire_window(input logic [2:0] d, input logic [3:0] w, input string name);
    int last;
    bit exp_p, exp_s, exp_r;
    last = 1 + int'(d) + int'(w) + 1 + HOLDOFF;
    bus.bx_delay    = d;
    bus.pulse_width = w;
    bus.fire_pulse  = 1'b1;
    for (int k = 1; k <= last; k++) begin
      tick;
      if (k == 1) begin
        bus.fire_pulse  = 1'b0;
        bus.bx_delay    = ~d;
        bus.pulse_width = ~w;
      end
      exp_p = (k >= 1 + int'(d)) && (k <= 1 + int'(d) + int'(w));
      exp_s = (k == 1 + int'(d) + int'(w));
      exp_r = (k == last);
      if (k == 1 + int'(d)) exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (bus.pulse_out !== exp_p) begin
        errors++;
        $display("FAIL %s pulse_out k=%0d: got %b expected %b", name, k, bus.pulse_out, exp_p);
      end
      checks++;
      if (bus.check_strobe !== exp_s) begin
        errors++;
        $display("FAIL %s check_strobe k=%0d: got %b expected %b", name, k, bus.check_strobe, exp_s);
      end
      checks++;
      if (bus.pulser_ready !== exp_r) begin
        errors++;
        $display("FAIL %s pulser_ready k=%0d: got %b expected %b", name, k, bus.pulser_ready, exp_r);
      end
      checks++;
      if (bus.pulse_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL %s pulse_cnt k=%0d: got %0d expected %0d", name, k, bus.pulse_cnt, exp_cnt);
      end
      checks++;
      if (bus.busy_drop !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_drop k=%0d: got %b expected 0", name, k, bus.busy_drop);
      end
    end
  endtask

  // Reset values, then a fire level held high across reset release.
  task automatic test_reset;
    reset = 1'b1;
    bus.fire_pulse = 1'b1;
    repeat (3) tick;
    checks++;
    if ({bus.pulse_out, bus.check_strobe, bus.pulser_ready, bus.busy_drop} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0010",
               {bus.pulse_out, bus.check_strobe, bus.pulser_ready, bus.busy_drop});
    end
    checks++;
    if (bus.pulse_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_pulse_cnt: got %0d expected 0", bus.pulse_cnt);
    end
    reset = 1'b0;
    exp_cnt = '0;
    for (int k = 0; k < 20; k++) begin
      tick;
      checks++;
      if ({bus.pulse_out, bus.pulser_ready, bus.pulse_cnt} !== {1'b0, 1'b1, 4'd0}) begin
        errors++;
        $display("FAIL level_held k=%0d: got out=%b rdy=%b cnt=%0d expected out=0 rdy=1 cnt=0",
                 k, bus.pulse_out, bus.pulser_ready, bus.pulse_cnt);
      end
    end
    bus.fire_pulse = 1'b0;
    tick;
  endtask

  task automatic test_delay_width;
    fire_window(3'd3, 4'd4, "delay3_width4");
    fire_window(3'd1, 4'd2, "delay1_width2");
  endtask

  task automatic test_min_max;
    fire_window(3'd0, 4'd0, "min_pulse");
    fire_window(3'd7, 4'd15, "max_pulse");
  endtask

  // Pulse k=1..5; busy edges sampled at end of k=2 and k=4.
  task automatic test_back_to_back;
    int  last;
    bit  exp_p, exp_s, exp_b, exp_r;
    last = REARM ? 24 : 14;
    bus.bx_delay    = 3'd0;
    bus.pulse_width = 4'd4;
    bus.fire_pulse  = 1'b1;
    for (int k = 1; k <= last; k++) begin
      tick;
      case (k)
        1: begin
          bus.fire_pulse  = 1'b0;
          bus.pulse_width = 4'd1;
        end
        2: bus.fire_pulse = 1'b1;
        3: bus.fire_pulse = 1'b0;
        4: bus.fire_pulse = 1'b1;
        5: bus.fire_pulse = 1'b0;
        default: ;
      endcase
      exp_p = (k <= 5) || (REARM && (k == 14 || k == 15));
      exp_s = (k == 5) || (REARM && k == 15);
      exp_b = (k == 5) || (!REARM && k == 3);
      exp_r = (k == last);
      if (k == 1 || (REARM && k == 14)) exp_cnt = exp_cnt + 1'b1;
      checks++;
      if ({bus.pulse_out, bus.check_strobe, bus.busy_drop, bus.pulser_ready} !==
          {exp_p, exp_s, exp_b, exp_r}) begin
        errors++;
        $display("FAIL busy_edge k=%0d: got out/strb/drop/rdy=%b expected %b", k,
                 {bus.pulse_out, bus.check_strobe, bus.busy_drop, bus.pulser_ready},
                 {exp_p, exp_s, exp_b, exp_r});
      end
      checks++;
      if (bus.pulse_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL busy_edge pulse_cnt k=%0d: got %0d expected %0d", k, bus.pulse_cnt, exp_cnt);
      end
    end
  endtask

  // 10-cycle pulse (k=1..10); reset sampled at the end of pulse cycle 2.
  task automatic test_reset_mid;
    bus.bx_delay    = 3'd0;
    bus.pulse_width = 4'd9;
    bus.fire_pulse  = 1'b1;
    tick;
    bus.fire_pulse = 1'b0;
    tick;
    checks++;
    if (bus.pulse_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre: got pulse_out=%b expected 1", bus.pulse_out);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_cnt = '0;
    checks++;
    if ({bus.pulse_out, bus.check_strobe, bus.pulser_ready, bus.pulse_cnt} !== {3'b001, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid: got out=%b strb=%b rdy=%b cnt=%0d expected 0 0 1 0",
               bus.pulse_out, bus.check_strobe, bus.pulser_ready, bus.pulse_cnt);
    end
    for (int k = 0; k < 12; k++) begin
      tick;
      checks++;
      if ({bus.pulse_out, bus.check_strobe, bus.pulser_ready} !== 3'b001) begin
        errors++;
        $display("FAIL reset_mid after k=%0d: got out/strb/rdy=%b expected 001",
                 k, {bus.pulse_out, bus.check_strobe, bus.pulser_ready});
      end
    end
  endtask

  task automatic test_wrap_clear;
    bit ok;
    for (int i = 0; i < 16; i++) fire_window(3'd0, 4'd0, "wrap");
    checks++;
    if (bus.pulse_cnt !== 4'd0) begin
      errors++;
      $display("FAIL wrap_16: got pulse_cnt=%0d expected 0", bus.pulse_cnt);
    end
    fire_window(3'd0, 4'd0, "after_wrap");
    checks++;
    if (bus.pulse_cnt !== 4'd1) begin
      errors++;
      $display("FAIL after_wrap: got pulse_cnt=%0d expected 1", bus.pulse_cnt);
    end
    // Clear in the same cycle as the increment: clear wins, pulse still fires.
    bus.bx_delay    = 3'd0;
    bus.pulse_width = 4'd0;
    bus.fire_pulse  = 1'b1;
    bus.cnt_rst     = 1'b1;
    tick;
    bus.fire_pulse = 1'b0;
    bus.cnt_rst    = 1'b0;
    exp_cnt = '0;
    checks++;
    if ({bus.pulse_out, bus.pulse_cnt} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL clear_vs_inc: got out=%b cnt=%0d expected out=1 cnt=0",
               bus.pulse_out, bus.pulse_cnt);
    end
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      tick;
      ok = bus.pulser_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: got pulser_ready=0 after 100 cycles expected 1");
    end
    checks++;
    if (bus.pulse_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clear_hold: got pulse_cnt=%0d expected 0", bus.pulse_cnt);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.fire_pulse  = 1'b0;
    bus.bx_delay    = 3'd0;
    bus.pulse_width = 4'd0;
    bus.cnt_rst     = 1'b0;
    exp_cnt         = '0;
    test_reset;
    test_delay_width;
    test_min_max;
    test_back_to_back;
    test_reset_mid;
    test_wrap_clear;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Sits downstream of the host register block.
- Converts the host-written fire_pulse level bit into one timed test pulse to the comparator pulser.
- Pulse start delay comes from bx_delay; pulse length comes from pulse_width.
- Returns pulser_ready for host readback, issues a one-cycle check strobe for the halfstrip/compout error counters, and keeps a count of fired pulses.

Parameters:
- HOLDOFF, 8: idle cycles after the pulse ends before a new fire is accepted (1..255).
- CNT_W, 16: width of the fired-pulse counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- fire_pulse  input  1  level from the host register; rising edge requests a pulse.
- bx_delay  input  3  start delay in clk cycles (0..7).
- pulse_width  input  4  pulse length code; actual length = pulse_width+1 cycles (1..16).
- cnt_rst  input  1  synchronous clear of pulse_cnt.
- pulse_out  output  1  registered pulse to the analog pulser.
- check_strobe  output  1  one-cycle strobe on the last cycle of pulse_out.
- pulser_ready  output  1  high only in IDLE.
- pulse_cnt  output  CNT_W  number of pulses fired; wraps.
- busy_drop  output  1  one-cycle flag when a fire edge is ignored.

Behaviour:
- Reset is synchronous and active-high. Every output and state register is registered.
- Reset values:
  - State: IDLE.
  - pulse_out, check_strobe, busy_drop: 0.
  - pulser_ready: 1.
  - pulse_cnt: 0.
  - fire_q (edge-detect register): 1, so a fire_pulse level held high through reset does not fire.
- Edge detect: fire_edge = fire_pulse & ~fire_q. fire_q <= fire_pulse every cycle.
- IDLE:
  - On fire_edge (cycle N), latch bx_delay into dly_cnt and pulse_width into wid_cnt.
  - Go to DELAY if bx_delay != 0, otherwise to PULSE.
  - pulser_ready drops at N+1.
- DELAY:
  - Decrement dly_cnt each cycle; go to PULSE when dly_cnt reaches 1.
  - pulse_out rises at N+1+bx_delay.
- PULSE:
  - pulse_out = 1. Decrement wid_cnt each cycle.
  - On the cycle wid_cnt = 0, assert check_strobe with pulse_out, then go to HOLDOFF.
  - pulse_out is high for exactly pulse_width+1 cycles.
  - pulse_cnt increments once, on the first PULSE cycle.
- HOLDOFF:
  - Count HOLDOFF cycles with pulse_out = 0, then go to IDLE.
  - pulser_ready returns high on the first IDLE cycle.
- Inputs bx_delay and pulse_width are sampled only at acceptance. Changes mid-operation have no effect on the current pulse.
- A fire_edge in any state other than IDLE is dropped (busy_drop pulses for 1 cycle, no queuing), unless the optional feature below is compiled in.
- cnt_rst clears pulse_cnt. If cnt_rst and an increment fall in the same cycle, cnt_rst wins (result 0).
- pulse_cnt wraps from all-ones to 0.
- Reset asserted mid-pulse: pulse_out is 0 on the next cycle and the FSM returns to IDLE. No check_strobe is issued for that pulse.
- Illegal state encodings recover to IDLE with pulse_out = 0.

Optional Feature:
- Macro: PULSE_GEN_REARM_EN.
- Defined:
  - A one-deep pending flag captures a fire_edge seen outside IDLE. busy_drop is asserted only if pending is already set.
  - At the HOLDOFF-to-IDLE transition with pending set, the FSM accepts immediately, sampling bx_delay and pulse_width at that cycle, and clears pending.
  - pulser_ready stays low through the rearmed pulse.
  - Reset clears pending.
- Undefined: no pending flag; every non-IDLE edge is dropped as described in Behaviour.

Test Plan:
- Delay and width: reset, then bx_delay=3, pulse_width=4, fire_pulse 0->1 at cycle N.
  - pulser_ready=0 at N+1.
  - pulse_out high N+4..N+8 (5 cycles); check_strobe only at N+8.
  - pulse_cnt=1.
  - pulser_ready=1 at N+9+8.
- Minimum pulse: bx_delay=0, pulse_width=0, edge at N -> pulse_out high only at N+1, with check_strobe at N+1.
- Level held through reset: fire_pulse held at 1 across reset release -> no pulse and pulse_cnt=0. A later 0->1 edge fires normally.
- Busy edge: second edge while in PULSE.
  - Macro off: busy_drop=1 for 1 cycle, only one pulse, pulse_cnt=1.
  - Macro on: second pulse starts after HOLDOFF, pulse_cnt=2.
- Reset mid-operation: reset during cycle 2 of a 10-cycle pulse -> pulse_out=0 next cycle, no check_strobe, pulser_ready=1, pulse_cnt=0.
- Counter wrap and clear (CNT_W=4): 16 pulses -> pulse_cnt=0. cnt_rst asserted on the same cycle as an increment -> pulse_cnt=0.
